// File: rtl/hamming_pkg.sv
// Shared constants, codeword layout and encoder for the Hamming(12,8) link.
package hamming_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 12;

    // Parity bit positions within the codeword (0-based; 1-based positions 1, 2, 4, 8).
    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;
    localparam int unsigned P3 = 3;
    localparam int unsigned P7 = 7;

    // Codeword position of data bit i.
    localparam logic [3:0] DATA_POS [DATA_W] = '{
        4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11
    };

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // SEC encoder: a single flip at 0-based bit p yields decoder syndrome p+1.
    function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c[DATA_POS[i]] = d[i];
        end
        c[P0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[P1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[P3] = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[P7] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return c;
    endfunction

endpackage

// File: rtl/hamming_tx_fifo.sv
// Two-entry codeword FIFO between the encoder and the serialiser.
module hamming_tx_fifo
    import hamming_pkg::*;
#(
    parameter int unsigned Width = CODE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Overflow/underflow requests are dropped rather than corrupting state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/hamming_tx.sv
// Hamming(12,8) serial transmitter: encode + optional bit flip, 2-deep FIFO, UART-style framer.
module hamming_tx
    import hamming_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        in_inj,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LastBit = 4'(CODE_W - 1);

    logic [CODE_W-1:0] enc_word;
    logic [CODE_W-1:0] inj_mask;
    logic [CODE_W-1:0] fifo_wdata;
    logic [CODE_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    tx_state_t         state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [CODE_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_end;

    // Injection mask: codes 1..12 flip code[in_inj-1]; 0 and 13..15 leave the word intact.
    always_comb begin
        inj_mask = '0;
        if ((in_inj >= 4'd1) && (in_inj <= 4'd12)) begin
            inj_mask[in_inj - 4'd1] = 1'b1;
        end
    end

    assign enc_word   = hamming_encode(in_data);
    assign fifo_wdata = enc_word ^ inj_mask;

    // Ready depends only on stored occupancy, never on in_valid.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    hamming_tx_fifo #(
        .Width (CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bit_end = (baud_q == BaudLast);

    // Framer next-state: baud timing, bit sequencing and FIFO pops.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = 4'd0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d    = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == LastBit) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when a word is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level follows the state being entered so tx comes straight off a flop.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Framer registers; reset abandons any frame in flight and drives the line idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 4'd0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_hamming_tx.sv
// Self-checking bench for hamming_tx: vector table, scoreboard-driven frame monitor, corner cases.
module tb_hamming_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 14 * CPB;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic [3:0] in_inj;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;

    hamming_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_inj   (in_inj),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int frames_done = 0;
    bit contig_chk  = 0;

    typedef struct {
        logic [11:0] code;
        logic [7:0]  data;
        logic [3:0]  syn;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  inj;
        logic [11:0] code;
    } vec_t;
    vec_t vecs[7];

    int dpos[8] = '{2, 4, 5, 6, 8, 9, 10, 11};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Encoder model: parity bits chosen so the XOR of set 1-based positions is zero.
    function automatic logic [11:0] enc_model(input logic [7:0] d);
        logic [11:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c[dpos[i]] = d[i];
        for (int p = 1; p <= 8; p = p * 2) begin
            logic par;
            par = 1'b0;
            for (int i = 0; i < 12; i++) if ((((i + 1) & p) != 0) && c[i]) par = ~par;
            c[p - 1] = par;
        end
        return c;
    endfunction

    // Decoder model: syndrome, single-bit correction, data extraction.
    task automatic decode(input logic [11:0] c_in, output logic [3:0] syn, output logic [7:0] d);
        logic [11:0] c;
        int s;
        c = c_in;
        s = 0;
        for (int i = 0; i < 12; i++) if (c[i]) s = s ^ (i + 1);
        syn = 4'(s);
        if (s >= 1 && s <= 12) c[s - 1] = ~c[s - 1];
        for (int i = 0; i < 8; i++) d[i] = c[dpos[i]];
    endtask

    task automatic finish_frame(input logic [13:0] bits, input bit hold_err);
        exp_t e;
        logic [11:0] code;
        logic [3:0]  syn;
        logic [7:0]  d;
        frames_done++;
        check("start bit", bits[0], 1'b0);
        check("stop bit", bits[13], 1'b1);
        check("bit held for CPB cycles", hold_err, 1'b0);
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected frame: got frame 0x%0h, required no frame", bits);
        end else begin
            e = sb.pop_front();
            code = bits[12:1];
            check("frame code", code, e.code);
            decode(code, syn, d);
            check("decoded syndrome", syn, e.syn);
            check("decoded data", d, e.data);
        end
    endtask

    // Line monitor: samples tx at negedges, reassembles 14-bit frames.
    initial begin
        logic [13:0] bits;
        int  mcyc;
        int  bi;
        int  gap;
        bit  active;
        bit  hold_err;
        bit  b2b;
        active = 0; mcyc = 0; gap = 0; hold_err = 0; b2b = 0; bits = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                b2b    = 0;
                gap    = 0;
            end else begin
                if (!active && tx === 1'b0) begin
                    if (b2b) check("no idle gap between frames", gap, 0);
                    active = 1; mcyc = 0; bits = '0; hold_err = 0; b2b = 0;
                end
                if (active) begin
                    bi = mcyc / CPB;
                    if (mcyc % CPB == 0) bits[bi] = tx;
                    else if (tx !== bits[bi]) hold_err = 1;
                    mcyc++;
                    if (mcyc == FRAME) begin
                        active = 0;
                        gap = 0;
                        finish_frame(bits, hold_err);
                        b2b = contig_chk && (sb.size() > 0);
                    end
                end else begin
                    gap++;
                end
            end
        end
    end

    initial begin
        #(20000 * 10);
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] inj, input logic [11:0] code,
                        input bit hold, output int acc_cyc);
        exp_t e;
        bit done;
        done = 0;
        acc_cyc = -1;
        @(negedge clk);
        in_data = d; in_inj = inj; in_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                acc_cyc = cyc;
                e.code = code;
                e.data = d;
                e.syn  = (inj >= 4'd1 && inj <= 4'd12) ? inj : 4'd0;
                sb.push_back(e);
                #1;
                if (!hold) in_valid = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept timeout: in_ready stayed 0, required 1");
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int limit);
        bit idle;
        idle = 0;
        for (int i = 0; i < limit && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        if (!idle) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle timeout: busy stayed 1, required 0");
        end
    endtask

    initial begin
        int t0, t1, t2, n, fexp;
        bit fell;
        rst_n = 1'b0; in_data = '0; in_inj = '0; in_valid = 1'b0;

        vecs[0] = '{data: 8'h01, inj: 4'd0,  code: 12'h007};
        vecs[1] = '{data: 8'hFF, inj: 4'd0,  code: 12'hF77};
        vecs[2] = '{data: 8'hFF, inj: 4'd4,  code: 12'hF7F};
        vecs[3] = '{data: 8'h5A, inj: 4'd13, code: 12'h550};
        vecs[4] = '{data: 8'h01, inj: 4'd12, code: 12'h807};
        vecs[5] = '{data: 8'h00, inj: 4'd1,  code: 12'h001};
        vecs[6] = '{data: 8'hA5, inj: 4'd15, code: 12'hA27};

        do_reset();

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle tx", tx, 1'b1);
            check("idle busy", busy, 1'b0);
            check("idle in_ready", in_ready, 1'b1);
        end

        // Latency of a single frame from an idle transmitter.
        send(8'h01, 4'd0, 12'h007, 1'b0, t0);
        check("tx still high on accept edge", tx, 1'b1);
        check("busy after accept", busy, 1'b1);
        @(posedge clk); #1;
        check("tx falls one cycle after accept", tx, 1'b0);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy cycles after tx falls", n, FRAME);
        @(negedge clk);
        check("frames after latency test", frames_done, 1);
        fexp = 1;

        // Vector table: one frame each.
        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].inj, vecs[i].code, 1'b0, t0);
            wait_idle(3 * FRAME);
            fexp++;
            check("frames after table vector", frames_done, fexp);
        end

        // Three bytes with in_valid held high; frames must be contiguous.
        contig_chk = 1;
        send(8'h00, 4'd0, enc_model(8'h00), 1'b1, t0);
        send(8'hA5, 4'd0, enc_model(8'hA5), 1'b1, t1);
        check("first two accepts consecutive", t1 - t0, 1);
        send(8'hFF, 4'd0, enc_model(8'hFF), 1'b0, t2);
        @(negedge clk);
        check("in_ready low when two words pending", in_ready, 1'b0);
        wait_idle(5 * FRAME);
        fexp += 3;
        check("frames after burst", frames_done, fexp);
        contig_chk = 0;

        // Reset in the middle of the data bits.
        send(8'h5A, 4'd0, 12'h550, 1'b0, t0);
        fell = 0;
        for (int i = 0; i < 50 && !fell; i++) begin
            @(negedge clk);
            if (tx == 1'b0) fell = 1;
        end
        check("frame started before reset", fell, 1'b1);
        repeat (CPB * 4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("tx high during reset", tx, 1'b1);
        check("busy low during reset", busy, 1'b0);
        check("in_ready high during reset", in_ready, 1'b1);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("tx idle after reset release", tx, 1'b1);
        check("busy low after reset release", busy, 1'b0);
        check("frames unchanged by aborted frame", frames_done, fexp);
        send(8'hA5, 4'd0, enc_model(8'hA5), 1'b0, t0);
        wait_idle(3 * FRAME);
        fexp++;
        check("frames after reset recovery", frames_done, fexp);

        check("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
